// File: rtl/rr_prio_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_prio_arbiter_pkg
// Brief    : Shared state encoding and width helper for the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_prio_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // $clog2 returns 0 for inputs of 1 or less; register widths need at least 1.
    function automatic int clog2_safe(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : rr_prio_arbiter_pkg
`default_nettype wire

// File: rtl/rr_prio_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : prio_pick
// Brief    : Combinational highest-index-first one-hot picker.
// Revision : 1.0 - initial release
// ============================================================================
module prio_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] onehot,
    output logic         any
);

    // Ascending scan: the last set bit seen, i.e. the highest, wins.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign any = |vec;

endmodule : prio_pick
`default_nettype wire

// File: rtl/rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_prio_arbiter
// Brief    : Registered round-robin arbiter with grant hold and optional
//            maximum-hold preemption.
// Revision : 1.0 - initial release
// ============================================================================
module rr_prio_arbiter
    import rr_prio_arbiter_pkg::*;
#(
    parameter int N       = 8,
    parameter int MAXHOLD = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0]                req,
    output logic [N-1:0]                gnt,
    output logic [clog2_safe(N)-1:0]    gnt_id,
    output logic                        busy
);

    localparam int                 c_id_w    = clog2_safe(N);
    localparam int                 c_cnt_w   = clog2_safe(MAXHOLD + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = (MAXHOLD == 0) ? '0 : c_cnt_w'(MAXHOLD - 1);

    arb_state_t          r_state;
    logic [N-1:0]        r_mask;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [N-1:0]        w_cand;
    logic [N-1:0]        w_masked;
    logic [N-1:0]        w_oh_m;
    logic [N-1:0]        w_oh_u;
    logic                w_any_m;
    logic                w_any_u;
    logic [N-1:0]        w_win;
    logic                w_hold_req;
    logic                w_preempt;

    arb_state_t          w_nxt_state;
    logic [N-1:0]        w_nxt_gnt;
    logic [N-1:0]        w_nxt_mask;
    logic [c_cnt_w-1:0]  w_nxt_cnt;
    logic [c_id_w-1:0]   w_nxt_id;

    // Excluding the current holder gives the release and preempt candidates in
    // one vector: on release its bit is already low, and when idle gnt is zero.
    assign w_cand   = req & ~gnt;
    assign w_masked = w_cand & r_mask;

    prio_pick #(.N(N)) u_pick_masked (
        .vec    (w_masked),
        .onehot (w_oh_m),
        .any    (w_any_m)
    );

    prio_pick #(.N(N)) u_pick_plain (
        .vec    (w_cand),
        .onehot (w_oh_u),
        .any    (w_any_u)
    );

    assign w_win      = w_any_m ? w_oh_m : w_oh_u;
    assign w_hold_req = |(req & gnt);
    assign w_preempt  = (MAXHOLD != 0) && w_hold_req && (r_cnt == c_cnt_max) && w_any_u;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = gnt;
        w_nxt_mask  = r_mask;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_u) begin
                    w_nxt_state = ST_BUSY;
                    w_nxt_gnt   = w_win;
                    w_nxt_mask  = w_win - N'(1);
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                if (!w_hold_req || w_preempt) begin
                    w_nxt_cnt = '0;
                    if (w_any_u) begin
                        w_nxt_gnt  = w_win;
                        w_nxt_mask = w_win - N'(1);
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_gnt   = '0;
                    end
                end else if (r_cnt != c_cnt_max) begin
                    w_nxt_cnt = r_cnt + c_cnt_w'(1);
                end
            end
        endcase
    end

    always_comb begin
        w_nxt_id = '0;
        for (int i = 0; i < N; i++) begin
            if (w_nxt_gnt[i]) begin
                w_nxt_id = c_id_w'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mask  <= '1;
            r_cnt   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_mask  <= w_nxt_mask;
            r_cnt   <= w_nxt_cnt;
            gnt     <= w_nxt_gnt;
            gnt_id  <= w_nxt_id;
            busy    <= |w_nxt_gnt;
        end
    end

endmodule : rr_prio_arbiter
`default_nettype wire

// File: tb/tb_rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_prio_arbiter
// Brief    : Scoreboard bench for rr_prio_arbiter (N=4, MAXHOLD 0 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_prio_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] ga;
        logic [3:0] gb;
    } exp_t;
    exp_t sb[$];

    // Reference model: holder index (-1 idle), hold count, scan start index.
    int m_hold [2];
    int m_cnt  [2];
    int m_start[2];

    rr_prio_arbiter #(.N(4), .MAXHOLD(0)) dut_a (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a)
    );

    rr_prio_arbiter #(.N(4), .MAXHOLD(4)) dut_b (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] g);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic int pick(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start - k + 4) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_hold[d]  = -1;
            m_cnt[d]   = 0;
            m_start[d] = 3;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r, output logic [3:0] g);
        int mh;
        int w;
        logic [3:0] others;
        mh = (d == 0) ? 0 : 4;
        w  = -2;
        if (m_hold[d] < 0) begin
            w = pick(r, m_start[d]);
        end else if (!r[m_hold[d]]) begin
            w = pick(r, m_start[d]);
            if (w < 0) begin
                m_hold[d] = -1;
                m_cnt[d]  = 0;
            end
        end else begin
            others = r;
            others[m_hold[d]] = 1'b0;
            if (mh != 0 && m_cnt[d] == mh - 1 && others != 0)
                w = pick(others, m_start[d]);
            else if (mh > 0 && m_cnt[d] < mh - 1)
                m_cnt[d]++;
        end
        if (w >= 0) begin
            m_hold[d]  = w;
            m_cnt[d]   = 0;
            m_start[d] = (w + 3) % 4;
        end
        g = (m_hold[d] < 0) ? 4'b0000 : 4'(1 << m_hold[d]);
    endtask

    // Called one time unit after a rising edge: drive, predict, advance, compare.
    task automatic cycle(input logic [3:0] r);
        exp_t e;
        req = r;
        model_step(0, r, e.ga);
        model_step(1, r, e.gb);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("gnt_a",  gnt_a,  e.ga);
        check("id_a",   id_a,   enc(e.ga));
        check("busy_a", busy_a, |e.ga);
        check("gnt_b",  gnt_b,  e.gb);
        check("id_b",   id_b,   enc(e.gb));
        check("busy_b", busy_b, |e.gb);
        check("onehot_a", $countones(gnt_a) <= 1, 1);
        check("onehot_b", $countones(gnt_b) <= 1, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},  {gnt_a, gnt_b}, 8'h00);
        check({tag, "_id"},   {id_a, id_b},   4'h0);
        check({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
    endtask

    initial begin
        logic [3:0] r;
        rst = 1'b1;
        req = 4'b1010;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("in_reset");
        rst = 1'b0;

        cycle(4'b1010);
        check("first_gnt", gnt_a, 4'b1000);
        check("first_id", id_a, 3);
        check("first_busy", busy_a, 1);

        cycle(4'b0010);
        check("handover_gnt", gnt_a, 4'b0010);
        check("handover_id", id_a, 1);
        cycle(4'b0000);
        check("idle_gnt", gnt_a, 4'b0000);
        check("idle_busy", busy_a, 0);

        cycle(4'b1101);
        check("rot_masked", gnt_a, 4'b0001);
        cycle(4'b1100);
        check("rot_wrap", gnt_a, 4'b1000);
        cycle(4'b0100);
        check("rot_next", gnt_a, 4'b0100);
        cycle(4'b0000);

        for (int c = 0; c < 12; c++) begin
            cycle(4'b0011);
            check("preempt_b", gnt_b, ((c / 4) % 2 == 0) ? 4'b0010 : 4'b0001);
            check("nopreempt_a", gnt_a, 4'b0010);
        end
        for (int c = 0; c < 10; c++) begin
            cycle(4'b0010);
            check("solo_hold_b", gnt_b, 4'b0010);
        end

        cycle(4'b0000);
        cycle(4'b0100);
        cycle(4'b0100);
        check("pre_reset_gnt", gnt_a, 4'b0100);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_held");
        rst = 1'b0;
        model_reset();
        cycle(4'b0101);
        check("post_reset_gnt", gnt_a, 4'b0100);
        check("post_reset_gnt_b", gnt_b, 4'b0100);

        r = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            cycle(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_prio_arbiter
`default_nettype wire
